// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetches one instruction at a time, decodes it and
// sequences the shared ALU, load/store handshake and register-file/PC write strobes.
module multicycle_ctrl #(
  parameter bit RESET_HALTED = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  input  logic        ifu_resp_valid,
  input  logic [31:0] inst,
  input  logic [31:0] alu_result,
  output logic        ASel,
  output logic        BSel,
  output logic [3:0]  ALUOp,
  output logic        IsSigned,
  output logic [31:0] imm,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic        mem_unsigned,
  input  logic        mem_resp_valid,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic        pc_src,
  output logic        halt,
  output logic        illegal,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_FETCH, S_WAIT_INST, S_DECODE, S_EXEC, S_BR_TGT,
    S_MEM_REQ, S_MEM_WAIT, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP
  } cls_t;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_XOR = 4'd4, ALU_SHIFL = 4'd5, ALU_SHIFR = 4'd6,
                         ALU_SLT = 4'd7, ALU_PASS = 4'd8;

  localparam logic [6:0] OPC_OP = 7'h33, OPC_OPIMM = 7'h13, OPC_LUI = 7'h37,
                         OPC_AUIPC = 7'h17, OPC_BRANCH = 7'h63, OPC_JAL = 7'h6F,
                         OPC_JALR = 7'h67, OPC_LOAD = 7'h03, OPC_STORE = 7'h23,
                         OPC_SYSTEM = 7'h73;

  state_t      r_state, w_next;
  cls_t        r_cls, w_cls;
  logic [31:0] r_inst, r_imm, w_imm;
  logic [3:0]  r_alu_op, w_op;
  logic        r_asel, r_bsel, r_signed, r_taken, r_halt, r_illegal;
  logic        w_asel, w_bsel, w_signed, w_ebreak, w_bad, w_taken;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

  assign w_opcode = r_inst[6:0];
  assign w_funct3 = r_inst[14:12];
  assign w_imm_i  = {{20{r_inst[31]}}, r_inst[31:20]};
  assign w_imm_s  = {{20{r_inst[31]}}, r_inst[31:25], r_inst[11:7]};
  assign w_imm_b  = {{19{r_inst[31]}}, r_inst[31], r_inst[7], r_inst[30:25], r_inst[11:8], 1'b0};
  assign w_imm_u  = {r_inst[31:12], 12'd0};
  assign w_imm_j  = {{11{r_inst[31]}}, r_inst[31], r_inst[19:12], r_inst[20], r_inst[30:21], 1'b0};

  // BEQ/BNE test SUB==0; the ordered compares test the SLT bit; funct3[0] inverts.
  assign w_taken = r_inst[14] ? (alu_result[0] ^ r_inst[12])
                              : ((alu_result == 32'd0) ^ r_inst[12]);

  always_comb begin
    w_op     = ALU_ADD;
    w_asel   = 1'b0;
    w_bsel   = 1'b0;
    w_signed = 1'b0;
    w_imm    = 32'd0;
    w_cls    = CLS_ALU;
    w_ebreak = 1'b0;
    w_bad    = 1'b0;
    case (w_opcode)
      OPC_OP, OPC_OPIMM: begin
        w_bsel = (w_opcode == OPC_OPIMM);
        w_imm  = (w_opcode == OPC_OPIMM) ? w_imm_i : 32'd0;
        case (w_funct3)
          3'b000:  w_op = (w_opcode == OPC_OP && r_inst[30]) ? ALU_SUB : ALU_ADD;
          3'b001:  w_op = ALU_SHIFL;
          3'b010:  begin w_op = ALU_SLT; w_signed = 1'b1; end
          3'b011:  w_op = ALU_SLT;
          3'b100:  w_op = ALU_XOR;
          3'b101:  begin w_op = ALU_SHIFR; w_signed = r_inst[30]; end
          3'b110:  w_op = ALU_OR;
          default: w_op = ALU_AND;
        endcase
      end
      OPC_LUI:    begin w_op = ALU_PASS; w_bsel = 1'b1; w_imm = w_imm_u; end
      OPC_AUIPC:  begin w_asel = 1'b1; w_bsel = 1'b1; w_imm = w_imm_u; end
      OPC_BRANCH: begin
        w_cls    = CLS_BRANCH;
        w_imm    = w_imm_b;
        w_op     = w_funct3[2] ? ALU_SLT : ALU_SUB;
        w_signed = w_funct3[2] & ~w_funct3[1];
      end
      OPC_JAL:    begin w_cls = CLS_JUMP; w_asel = 1'b1; w_bsel = 1'b1; w_imm = w_imm_j; end
      OPC_JALR:   begin w_cls = CLS_JUMP; w_bsel = 1'b1; w_imm = w_imm_i; end
      OPC_LOAD:   begin w_cls = CLS_LOAD; w_bsel = 1'b1; w_imm = w_imm_i; end
      OPC_STORE:  begin w_cls = CLS_STORE; w_bsel = 1'b1; w_imm = w_imm_s; end
      OPC_SYSTEM: begin
        if (r_inst == 32'h0010_0073) w_ebreak = 1'b1;
        else                         w_bad    = 1'b1;
      end
      default:    w_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RESET_HALTED ? S_HALT : S_FETCH;
    else     r_state <= w_next;
  end

  // Handshakes: a transfer happens on a posedge where the FSM's valid and the
  // partner's ready/valid are both high; a request stays up until accepted.
  always_comb begin
    w_next        = r_state;
    ifu_req_valid = 1'b0;
    mem_req_valid = 1'b0;
    mem_we        = 1'b0;
    rf_we         = 1'b0;
    pc_we         = 1'b0;
    wb_sel        = 2'd0;
    pc_src        = 1'b0;
    case (r_state)
      S_FETCH: begin
        ifu_req_valid = 1'b1;
        if (ifu_req_ready) w_next = S_WAIT_INST;
      end
      S_WAIT_INST: if (ifu_resp_valid) w_next = S_DECODE;
      S_DECODE:    w_next = (w_ebreak || w_bad) ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (r_cls)
          CLS_BRANCH:          w_next = S_BR_TGT;
          CLS_LOAD, CLS_STORE: w_next = S_MEM_REQ;
          default:             w_next = S_WB;
        endcase
      end
      S_BR_TGT: w_next = S_WB;
      S_MEM_REQ: begin
        mem_req_valid = 1'b1;
        mem_we        = (r_cls == CLS_STORE);
        if (mem_req_ready) w_next = S_MEM_WAIT;
      end
      S_MEM_WAIT: if (mem_resp_valid) w_next = S_WB;
      S_WB: begin
        pc_we  = 1'b1;
        w_next = S_FETCH;
        case (r_cls)
          CLS_ALU:    rf_we = 1'b1;
          CLS_LOAD:   begin rf_we = 1'b1; wb_sel = 2'd1; end
          CLS_BRANCH: pc_src = r_taken;
          CLS_JUMP:   begin rf_we = 1'b1; wb_sel = 2'd2; pc_src = 1'b1; end
          default:    rf_we = 1'b0;
        endcase
        if (rd_addr == 5'd0) rf_we = 1'b0;
      end
      S_HALT: if (RESET_HALTED && start && !r_halt && !r_illegal) w_next = S_FETCH;
      default: w_next = S_FETCH;
    endcase
    // Strobes drop the moment reset rises, before the async state reset lands.
    if (rst) begin
      ifu_req_valid = 1'b0;
      mem_req_valid = 1'b0;
      mem_we        = 1'b0;
      rf_we         = 1'b0;
      pc_we         = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst    <= 32'h0000_0013;
      r_imm     <= 32'd0;
      r_alu_op  <= ALU_ADD;
      r_asel    <= 1'b0;
      r_bsel    <= 1'b0;
      r_signed  <= 1'b0;
      r_cls     <= CLS_ALU;
      r_taken   <= 1'b0;
      r_halt    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_WAIT_INST: if (ifu_resp_valid) r_inst <= inst;
        S_DECODE: begin
          r_alu_op  <= w_op;
          r_asel    <= w_asel;
          r_bsel    <= w_bsel;
          r_signed  <= w_signed;
          r_imm     <= w_imm;
          r_cls     <= w_cls;
          r_halt    <= w_ebreak;
          r_illegal <= w_bad;
        end
        S_EXEC: if (r_cls == CLS_BRANCH) begin
          // Compare result is consumed here; the ALU is then retargeted to PC+imm.
          r_taken  <= w_taken;
          r_alu_op <= ALU_ADD;
          r_asel   <= 1'b1;
          r_bsel   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ASel         = r_asel;
  assign BSel         = r_bsel;
  assign ALUOp        = r_alu_op;
  assign IsSigned     = r_signed;
  assign imm          = r_imm;
  assign rs1_addr     = r_inst[19:15];
  assign rs2_addr     = r_inst[24:20];
  assign rd_addr      = r_inst[11:7];
  assign mem_size     = r_inst[13:12];
  assign mem_unsigned = r_inst[14];
  assign halt         = r_halt;
  assign illegal      = r_illegal;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: table of instructions with expected decode/WB results,
// scoreboarded at the WB strobe, plus hand sequences for stalls, halt and reset.
module tb_multicycle_ctrl;

  localparam int SW = 47;
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3,
                         A_XOR = 4'd4, A_SHL = 4'd5, A_SHR = 4'd6, A_SLT = 4'd7,
                         A_PASS = 4'd8;
  localparam logic [3:0] ST_FETCH = 4'd0, ST_EXEC = 4'd3, ST_MEM_WAIT = 4'd6, ST_HALT = 4'd8;

  logic        clk, rst, start;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] inst, alu_result, imm;
  logic        ASel, BSel, IsSigned;
  logic [3:0]  ALUOp, dbg_state;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_unsigned, mem_resp_valid;
  logic [1:0]  mem_size, wb_sel;
  logic        rf_we, pc_we, pc_src, halt, illegal;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_resp_valid(ifu_resp_valid), .inst(inst), .alu_result(alu_result),
    .ASel(ASel), .BSel(BSel), .ALUOp(ALUOp), .IsSigned(IsSigned), .imm(imm),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .mem_resp_valid(mem_resp_valid),
    .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_src(pc_src),
    .halt(halt), .illegal(illegal), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] ins;
    logic [31:0] alu;
    logic [3:0]  ex_op;
    logic        chk_sg;
    logic        ex_sg;
    logic [3:0]  wb_op;
    logic        asel;
    logic        bsel;
    logic        chk_imm;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rf_we;
    logic        chk_wb;
    logic [1:0]  wb_sel;
    logic        pc_src;
    int          cyc;
    logic        is_mem;
    logic        m_we;
    logic [1:0]  m_sz;
    logic        m_un;
  } vec_t;

  vec_t vt[24];
  int checks = 0;
  int failures = 0;
  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] mask_q[$];

  logic [3:0] obs_exec_op;
  logic       obs_exec_sg, obs_mem_we, obs_mem_un;
  logic [1:0] obs_mem_sz;
  int         obs_mem_cycles;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard: one expected WB signature per instruction, popped at the pc_we strobe
  always @(negedge clk) begin
    if (pc_we) begin
      logic [SW-1:0] act, e, m;
      act = {ALUOp, ASel, BSel, imm, rd_addr, rf_we, wb_sel, pc_src};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wb_unexpected: got %h expected no WB", act);
      end else begin
        e = exp_q.pop_front();
        m = mask_q.pop_front();
        if ((act & m) !== (e & m)) begin
          failures++;
          $display("FAIL wb_sig: got %h expected %h (mask %h)", act & m, e & m, m);
        end
      end
    end
  end

  task automatic idle_inputs();
    ifu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
  endtask

  // driver: serves one instruction; returns at the WB (or halt) cycle
  task automatic run_inst(input logic [31:0] ins, input logic [31:0] alu_val,
                          input int fetch_dly, input int mem_dly, input bit abort_mw,
                          output int cycles);
    int cyc, fcnt, mcnt;
    bit started, f_resp, m_resp;
    cyc = 0; fcnt = 0; mcnt = 0; started = 0; f_resp = 0; m_resp = 0; cycles = -1;
    obs_exec_op = 4'hF; obs_exec_sg = 1'bx; obs_mem_cycles = 0;
    alu_result = alu_val;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (ifu_req_valid) started = 1;
      if (started) cyc++;
      if (dbg_state == ST_EXEC) begin obs_exec_op = ALUOp; obs_exec_sg = IsSigned; end
      if (mem_req_valid) begin
        obs_mem_cycles++;
        obs_mem_we = mem_we; obs_mem_sz = mem_size; obs_mem_un = mem_unsigned;
      end
      if (m_resp && abort_mw) begin
        check("abort_in_mem_wait", {28'd0, dbg_state}, {28'd0, ST_MEM_WAIT});
        idle_inputs();
        rst = 1'b1;
        #1;
        check("rst_state_fetch", {28'd0, dbg_state}, {28'd0, ST_FETCH});
        check("rst_strobes", {28'd0, ifu_req_valid, mem_req_valid, rf_we, pc_we}, 32'd0);
        return;
      end
      if (pc_we || halt || illegal) begin
        cycles = cyc;
        idle_inputs();
        return;
      end
      ifu_resp_valid = f_resp;
      inst = f_resp ? ins : $urandom();
      f_resp = 0;
      ifu_req_ready = 1'b0;
      if (ifu_req_valid) begin
        if (fcnt >= fetch_dly) begin ifu_req_ready = 1'b1; f_resp = 1; end
        else begin ifu_resp_valid = 1'b1; fcnt++; end
      end
      mem_resp_valid = m_resp;
      m_resp = 0;
      mem_req_ready = 1'b0;
      if (mem_req_valid) begin
        if (mcnt >= mem_dly) begin mem_req_ready = 1'b1; m_resp = 1; end
        else mcnt++;
      end
    end
    checks++;
    failures++;
    $display("FAIL run_timeout: got no WB/halt for %h expected completion", ins);
    idle_inputs();
  endtask

  task automatic apply_vec(input vec_t v, input int fdly, input int mdly, input string tag);
    int cyc;
    exp_q.push_back({v.wb_op, v.asel, v.bsel, v.imm, v.rd, v.rf_we, v.wb_sel, v.pc_src});
    mask_q.push_back({4'hF, 1'b1, 1'b1, {32{v.chk_imm}}, 5'h1F, 1'b1, {2{v.chk_wb}}, 1'b1});
    run_inst(v.ins, v.alu, fdly, mdly, 1'b0, cyc);
    check({tag, "_cycles"}, cyc, v.cyc + fdly + mdly);
    check({tag, "_exec_op"}, {28'd0, obs_exec_op}, {28'd0, v.ex_op});
    if (v.chk_sg) check({tag, "_exec_signed"}, {31'd0, obs_exec_sg}, {31'd0, v.ex_sg});
    if (v.is_mem) begin
      check({tag, "_mem_valid_cycles"}, obs_mem_cycles, mdly + 1);
      check({tag, "_mem_attr"}, {28'd0, obs_mem_we, obs_mem_sz, obs_mem_un},
            {28'd0, v.m_we, v.m_sz, v.m_un});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int cyc;
    //         ins           alu    ex_op  csg sg  wb_op  as bs ci imm           rd  rf cw wbs pcs cyc mem we sz     un
    vt[0]  = '{32'h00500093, 32'h0, A_ADD, 0, 0, A_ADD, 0, 1, 1, 32'h00000005, 1,  1, 1, 0, 0, 5, 0, 0, 2'd0, 0};
    vt[1]  = '{32'h402081B3, 32'h0, A_SUB, 0, 0, A_SUB, 0, 0, 0, 32'h0,        3,  1, 1, 0, 0, 5, 0, 0, 2'd0, 0};
    vt[2]  = '{32'hFFF0A213, 32'h0, A_SLT, 1, 1, A_SLT, 0, 1, 1, 32'hFFFFFFFF, 4,  1, 1, 0, 0, 5, 0, 0, 2'd0, 0};
    vt[3]  = '{32'h0020B2B3, 32'h0, A_SLT, 1, 0, A_SLT, 0, 0, 0, 32'h0,        5,  1, 1, 0, 0, 5, 0, 0, 2'd0, 0};
    vt[4]  = '{32'h4030D313, 32'h0, A_SHR, 1, 1, A_SHR, 0, 1, 1, 32'h00000403, 6,  1, 1, 0, 0, 5, 0, 0, 2'd0, 0};
    vt[5]  = '{32'h0020D3B3, 32'h0, A_SHR, 1, 0, A_SHR, 0, 0, 0, 32'h0,        7,  1, 1, 0, 0, 5, 0, 0, 2'd0, 0};
    vt[6]  = '{32'h00F0C413, 32'h0, A_XOR, 0, 0, A_XOR, 0, 1, 1, 32'h0000000F, 8,  1, 1, 0, 0, 5, 0, 0, 2'd0, 0};
    vt[7]  = '{32'h0020E4B3, 32'h0, A_OR,  0, 0, A_OR,  0, 0, 0, 32'h0,        9,  1, 1, 0, 0, 5, 0, 0, 2'd0, 0};
    vt[8]  = '{32'hFF00F513, 32'h0, A_AND, 0, 0, A_AND, 0, 1, 1, 32'hFFFFFFF0, 10, 1, 1, 0, 0, 5, 0, 0, 2'd0, 0};
    vt[9]  = '{32'h002095B3, 32'h0, A_SHL, 0, 0, A_SHL, 0, 0, 0, 32'h0,        11, 1, 1, 0, 0, 5, 0, 0, 2'd0, 0};
    vt[10] = '{32'h12345637, 32'h0, A_PASS,0, 0, A_PASS,0, 1, 1, 32'h12345000, 12, 1, 1, 0, 0, 5, 0, 0, 2'd0, 0};
    vt[11] = '{32'h00001697, 32'h0, A_ADD, 0, 0, A_ADD, 1, 1, 1, 32'h00001000, 13, 1, 1, 0, 0, 5, 0, 0, 2'd0, 0};
    vt[12] = '{32'h010000EF, 32'h0, A_ADD, 0, 0, A_ADD, 1, 1, 1, 32'h00000010, 1,  1, 1, 2, 1, 5, 0, 0, 2'd0, 0};
    vt[13] = '{32'h00008067, 32'h0, A_ADD, 0, 0, A_ADD, 0, 1, 1, 32'h0,        0,  0, 1, 2, 1, 5, 0, 0, 2'd0, 0};
    vt[14] = '{32'h00100013, 32'h0, A_ADD, 0, 0, A_ADD, 0, 1, 1, 32'h00000001, 0,  0, 1, 0, 0, 5, 0, 0, 2'd0, 0};
    vt[15] = '{32'h00000463, 32'h0, A_SUB, 0, 0, A_ADD, 1, 1, 1, 32'h00000008, 8,  0, 0, 0, 1, 6, 0, 0, 2'd0, 0};
    vt[16] = '{32'h00001463, 32'h0, A_SUB, 0, 0, A_ADD, 1, 1, 1, 32'h00000008, 8,  0, 0, 0, 0, 6, 0, 0, 2'd0, 0};
    vt[17] = '{32'h00001463, 32'h5, A_SUB, 0, 0, A_ADD, 1, 1, 1, 32'h00000008, 8,  0, 0, 0, 1, 6, 0, 0, 2'd0, 0};
    vt[18] = '{32'hFE20CEE3, 32'h1, A_SLT, 1, 1, A_ADD, 1, 1, 1, 32'hFFFFFFFC, 29, 0, 0, 0, 1, 6, 0, 0, 2'd0, 0};
    vt[19] = '{32'h0020F463, 32'h1, A_SLT, 1, 0, A_ADD, 1, 1, 1, 32'h00000008, 8,  0, 0, 0, 0, 6, 0, 0, 2'd0, 0};
    vt[20] = '{32'h0020D463, 32'h0, A_SLT, 1, 1, A_ADD, 1, 1, 1, 32'h00000008, 8,  0, 0, 0, 1, 6, 0, 0, 2'd0, 0};
    vt[21] = '{32'h0040A103, 32'h100,A_ADD,0, 0, A_ADD, 0, 1, 1, 32'h00000004, 2,  1, 1, 1, 0, 7, 1, 0, 2'b10, 0};
    vt[22] = '{32'h0020A423, 32'h100,A_ADD,0, 0, A_ADD, 0, 1, 1, 32'h00000008, 8,  0, 0, 0, 0, 7, 1, 1, 2'b10, 0};
    vt[23] = '{32'h0000C183, 32'h100,A_ADD,0, 0, A_ADD, 0, 1, 1, 32'h0,        3,  1, 1, 1, 0, 7, 1, 0, 2'b00, 1};

    rst = 1'b1; start = 1'b0; inst = 32'h0; alu_result = 32'h0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    check("reset_strobes", {28'd0, ifu_req_valid, mem_req_valid, rf_we, pc_we}, 32'd0);
    check("reset_flags", {30'd0, halt, illegal}, 32'd0);
    check("reset_alu_ctrl", {26'd0, ALUOp, ASel, BSel}, 32'd0);
    check("reset_state", {28'd0, dbg_state}, {28'd0, ST_FETCH});
    rst = 1'b0;
    #1;
    check("fetch_after_reset", {31'd0, ifu_req_valid}, 32'd1);

    for (int i = 0; i < 24; i++) apply_vec(vt[i], 0, 0, $sformatf("v%0d", i));

    // load with mem_req_ready held off three cycles
    apply_vec(vt[21], 0, 3, "lw_stall");
    // store with a one-cycle memory stall, then operand indices from the held word
    apply_vec(vt[22], 0, 1, "sw_stall");
    check("sw_rs_addrs", {22'd0, rs1_addr, rs2_addr}, {22'd0, 5'd1, 5'd2});
    // fetch stalled two cycles with junk ifu_resp_valid pulses that must be ignored
    apply_vec(vt[0], 2, 0, "fetch_stall");

    // reset during MEM_WAIT: no WB strobe, back to FETCH
    run_inst(vt[21].ins, 32'h100, 0, 0, 1'b1, cyc);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("refetch_after_abort", {31'd0, ifu_req_valid}, 32'd1);
    apply_vec(vt[6], 0, 0, "after_abort");

    // ebreak: halt and stay quiet, start ignored with RESET_HALTED=0
    run_inst(32'h00100073, 32'h0, 0, 0, 1'b0, cyc);
    check("ebreak_flags", {30'd0, halt, illegal}, 32'd2);
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("halt_quiet", {28'd0, ifu_req_valid, mem_req_valid, rf_we, pc_we}, 32'd0);
    end
    start = 1'b0;
    check("halt_held", {28'd0, dbg_state}, {28'd0, ST_HALT});
    do_reset();
    check("halt_cleared", {30'd0, halt, illegal}, 32'd0);

    // unsupported opcode
    run_inst(32'h0000007F, 32'h0, 0, 0, 1'b0, cyc);
    check("illegal_flags", {30'd0, halt, illegal}, 32'd1);
    @(negedge clk);
    check("illegal_quiet", {28'd0, ifu_req_valid, mem_req_valid, rf_we, pc_we}, 32'd0);
    do_reset();
    apply_vec(vt[12], 0, 0, "after_illegal");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the NPC core. It fetches one RV32I instruction at a time over a valid/ready instruction port and decodes it.
- It sequences the shared ALU (operand selects, op, signedness) across EXEC, branch-target, memory and writeback states, and issues the load/store handshake.
- It drives register-file and PC write enables. Only one instruction is in flight; there is no pipelining.

Parameters:
- RESET_HALTED, 0, when 1 the FSM leaves reset in HALT and needs `start` to begin fetching.

Ports:
- clk  in  1  core clock; all state updates on posedge
- rst  in  1  asynchronous active-high reset
- start  in  1  leave HALT and go to FETCH; only used when RESET_HALTED=1
- ifu_req_valid  out  1  instruction fetch request at current PC
- ifu_req_ready  in  1  fetch request accepted
- ifu_resp_valid  in  1  inst is valid this cycle
- inst  in  32  fetched instruction word
- alu_result  in  32  combinational ALU output
- ASel  out  1  0=rs1 (OPA_FROM_RS1), 1=PC (OPA_FROM_PC)
- BSel  out  1  0=rs2 (OPB_FROM_RS2), 1=imm (OPB_FROM_IMM)
- ALUOp  out  4  ADD=0 SUB=1 AND=2 OR=3 XOR=4 SHIFL=5 SHIFR=6 SLT=7 PASS=8
- IsSigned  out  1  1=TYPE_SIGNED, 0=TYPE_UNSIGNED
- imm  out  32  sign-extended immediate (I/S/B/U/J per opcode)
- rs1_addr, rs2_addr, rd_addr  out  5 each  register indices from held inst
- mem_req_valid  out  1  load/store request; address = alu_result
- mem_req_ready  in  1  memory accepted request
- mem_we  out  1  1=store
- mem_size  out  2  funct3[1:0] of held inst
- mem_unsigned  out  1  funct3[2] of held inst
- mem_resp_valid  in  1  load data ready / store complete
- rf_we  out  1  register-file write strobe; forced 0 when rd=0
- wb_sel  out  2  0=ALU, 1=load data, 2=PC+4
- pc_we  out  1  PC update strobe
- pc_src  out  1  0=PC+4, 1=alu_result with bit0 cleared
- halt  out  1  ebreak executed
- illegal  out  1  unsupported opcode seen

Behaviour:
- States: FETCH, WAIT_INST, DECODE, EXEC, BR_TGT, MEM_REQ, MEM_WAIT, WB, HALT.
- Reset (async): state=FETCH, or HALT if RESET_HALTED; held inst=0x00000013 (nop); taken=0. All strobes (ifu_req_valid, mem_req_valid, rf_we, pc_we) are 0. halt=0, illegal=0, ALUOp=ADD, ASel=BSel=0.
- FETCH: ifu_req_valid=1 until ifu_req_ready. Go to WAIT_INST on the ready cycle.
- WAIT_INST: wait for ifu_resp_valid, latch inst, go to DECODE. ifu_resp_valid outside WAIT_INST is ignored.
- DECODE: register all ALU controls, imm, reg addresses and the instruction class. These stay stable from EXEC through WB.
- DECODE, ebreak: go to HALT with halt=1.
- DECODE, unknown opcode: go to HALT with illegal=1.
- EXEC, OP/OP-IMM: ASel=rs1, BSel=rs2/imm. funct3 maps to ADD/SUB (funct7[5] selects SUB, OP only), SLL, SLT(signed)/SLTU(unsigned), XOR, SRL/SRA (IsSigned=funct7[5]), OR, AND. Then WB.
- EXEC, LUI: PASS with BSel=imm. AUIPC: ADD with ASel=PC, BSel=imm. Both then WB.
- EXEC, branch: ASel=rs1, BSel=rs2.
  - BEQ/BNE: SUB; taken = (alu_result==0) xor funct3[0].
  - BLT/BGE: SLT signed; BLTU/BGEU: SLT unsigned; taken = alu_result[0] xor funct3[0].
  - Latch taken, go to BR_TGT.
- BR_TGT: ADD with ASel=PC, BSel=imm, then WB.
- EXEC, JAL: ADD PC+imm. JALR: ADD rs1+imm. Both then WB.
- EXEC, LOAD/STORE: ADD rs1+imm, then MEM_REQ.
- MEM_REQ: mem_req_valid=1 and mem_we=store, held until mem_req_ready, then MEM_WAIT.
- MEM_WAIT: wait for mem_resp_valid, then WB.
- WB is exactly one cycle: pc_we=1, rf_we per class, then FETCH.
  - ALU class: rf_we=1, wb_sel=0, pc_src=0.
  - Load: rf_we=1, wb_sel=1, pc_src=0.
  - Store: rf_we=0, pc_src=0.
  - Branch: rf_we=0, pc_src=taken.
  - JAL/JALR: rf_we=1, wb_sel=2, pc_src=1.
- HALT: all strobes 0; halt/illegal held. Exit only via rst, or via start when RESET_HALTED=1 and halt=illegal=0.
- Latency with zero-wait memory (ready same cycle, response next cycle):
  - ALU/LUI/AUIPC/JAL/JALR: 5 cycles per instruction.
  - Branch: 6 cycles.
  - Load/store: 7 cycles.
- Reset asserted in any state returns to the reset values immediately. Pending ifu/mem requests are dropped and no WB strobe is emitted.
- A ready or valid input that arrives in the same cycle the request is first raised is accepted that cycle.

Test Plan:
- addi x1,x0,5 (0x00500093), zero-wait memory -> WB on cycle 5: rf_we=1, rd_addr=1, ALUOp=ADD, BSel=1, imm=5, pc_we=1, pc_src=0.
- beq x0,x0,8 (0x00000463) -> EXEC ALUOp=SUB; BR_TGT ASel=1, BSel=1, imm=8; WB pc_src=1, rf_we=0; 6 cycles total.
- lw x2,4(x1) (0x0040A103) with mem_req_ready delayed 3 cycles -> mem_req_valid held 4 cycles; WB wb_sel=1, rd_addr=2, mem_size=2'b10, mem_unsigned=0.
- sw x2,8(x1) (0x0020A423) -> mem_we=1, imm=8; WB rf_we=0, pc_we=1.
- ebreak (0x00100073) -> halt=1, all strobes 0 thereafter; opcode 0x7F -> illegal=1.
- rst pulsed during MEM_WAIT -> mem_req_valid=0 and state=FETCH immediately; no rf_we or pc_we pulse.
